// File: rtl/pb_seg_ctrl.sv
// -----------------------------------------------------------------------------
// pb_seg_ctrl
//
// Memory-mapped push-button and 4-digit seven-segment display controller that
// sits on an 8-bit CPU data-memory bus.
//
// Address map (io_sel is high for 0xFB..0xFF):
//   0xFB        PB_STATE  read-only  {5'b0, debounced buttons}
//   0xFC..0xFF  DIG0..3   read/write active-high segment pattern per digit
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst    in   1  synchronous active-high reset
//   addr   in   8  CPU data address
//   wdata  in   8  CPU store data
//   we     in   1  CPU store strobe
//   rdata  out  8  combinational read data for addr (0 outside the I/O window)
//   io_sel out  1  addr falls in the I/O window; top level muxes rdata and
//                  blocks RAM writes with it
//   pb_in  in   3  raw asynchronous buttons (bit0 center, bit1 left, bit2 right)
//   seg_n  out  8  active-low segments, bit7 = dp, bits 6:0 = g..a (registered)
//   an_n   out  4  active-low digit anodes, bit k = digit k (registered)
// -----------------------------------------------------------------------------
module pb_seg_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] SCAN_CYCLES     = 16'd25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       we,
  output logic [7:0] rdata,
  output logic       io_sel,
  input  logic [2:0] pb_in,
  output logic [7:0] seg_n,
  output logic [3:0] an_n
);

  localparam logic [7:0]  ADDR_PB   = 8'hFB;
  localparam logic [15:0] DEB_LAST  = DEBOUNCE_CYCLES - 16'd1;
  localparam logic [15:0] SCAN_LAST = SCAN_CYCLES - 16'd1;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser; pb_in feeds nothing except sync1.
  // ---------------------------------------------------------------------------
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = pb_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-button debounce. The counter only runs while the synchronised level
  // disagrees with the accepted level; any return to agreement restarts it,
  // so a glitch shorter than DEBOUNCE_CYCLES can never be accepted.
  // ---------------------------------------------------------------------------
  logic [2:0] pb_stable;

  for (genvar gi = 0; gi < 3; gi++) begin : g_deb
    logic [15:0] cnt_q, cnt_d;
    logic        stable_q, stable_d;

    always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync2_q[gi] == stable_q) begin
        cnt_d = 16'd0;
      end else if (cnt_q >= DEB_LAST) begin
        // >= rather than == keeps the counter from ever running past its limit
        stable_d = sync2_q[gi];
        cnt_d    = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q    <= 16'd0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign pb_stable[gi] = stable_q;
  end

  // ---------------------------------------------------------------------------
  // Digit pattern registers DIG0..DIG3. Reset wins over a same-cycle store.
  // ---------------------------------------------------------------------------
  logic [7:0] dig_val [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_dig
    localparam logic [7:0] DIG_ADDR = 8'hFC + 8'(gi);

    logic [7:0] dig_q, dig_d;

    always_comb begin
      dig_d = dig_q;
      if (we && (addr == DIG_ADDR)) begin
        dig_d = wdata;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dig_q <= 8'h00;
      end else begin
        dig_q <= dig_d;
      end
    end

    assign dig_val[gi] = dig_q;
  end

  // ---------------------------------------------------------------------------
  // CPU read path (combinational).
  // ---------------------------------------------------------------------------
  always_comb begin
    io_sel = (addr >= ADDR_PB);
    rdata  = 8'h00;
    if (addr == ADDR_PB) begin
      rdata = {5'b00000, pb_stable};
    end else if (io_sel) begin
      rdata = dig_val[addr[1:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan FSM. Each digit is lit for SCAN_CYCLES cycles followed by a
  // single all-off cycle so the anode switch never overlaps the old pattern.
  // The digit index advances when leaving SHOW, so during BLANK it already
  // points at the next digit.
  // ---------------------------------------------------------------------------
  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_e;

  scan_state_e state_q, state_d;
  logic [1:0]  scan_dig_q, scan_dig_d;
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [7:0]  seg_n_q, seg_n_d;
  logic [3:0]  an_n_q, an_n_d;

  always_comb begin
    state_d    = state_q;
    scan_dig_d = scan_dig_q;
    scan_cnt_d = scan_cnt_q;
    an_n_d     = 4'b1111;
    seg_n_d    = 8'hFF;

    unique case (state_q)
      SHOW: begin
        // Pattern is read live from DIG, so stores show up on the next cycle.
        an_n_d  = ~(4'b0001 << scan_dig_q);
        seg_n_d = ~dig_val[scan_dig_q];
        if (scan_cnt_q >= SCAN_LAST) begin
          state_d    = BLANK;
          scan_cnt_d = 16'd0;
          scan_dig_d = scan_dig_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + 16'd1;
        end
      end
      BLANK: begin
        state_d = SHOW;
      end
      default: begin
        state_d = SHOW;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SHOW;
      scan_dig_q <= 2'd0;
      scan_cnt_q <= 16'd0;
      seg_n_q    <= 8'hFF;
      an_n_q     <= 4'b1111;
    end else begin
      state_q    <= state_d;
      scan_dig_q <= scan_dig_d;
      scan_cnt_q <= scan_cnt_d;
      seg_n_q    <= seg_n_d;
      an_n_q     <= an_n_d;
    end
  end

  assign seg_n = seg_n_q;
  assign an_n  = an_n_q;

endmodule

// File: tb/tb_pb_seg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pb_seg_ctrl
//
// Directed bench for pb_seg_ctrl with DEBOUNCE_CYCLES=8 and SCAN_CYCLES=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Scan expectations come from the fixed 20-cycle period counted from the first
// edge after reset: within each 5-cycle slot, 4 lit cycles then 1 blank.
// -----------------------------------------------------------------------------
module tb_pb_seg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic [7:0] rdata;
  logic       io_sel;
  logic [2:0] pb_in;
  logic [7:0] seg_n;
  logic [3:0] an_n;

  int tests = 0;
  int fails = 0;
  int n     = 0;   // rising edges since reset released
  int g;
  int k;

  logic [7:0] exp_dig [4];
  logic [7:0] vals    [4];

  pb_seg_ctrl #(
    .DEBOUNCE_CYCLES(16'd8),
    .SCAN_CYCLES    (16'd4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .io_sel(io_sel),
    .pb_in (pb_in),
    .seg_n (seg_n),
    .an_n  (an_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) n = 0;
    else     n = n + 1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_an(input int e);
    int p;
    logic [3:0] one;
    one = 4'b0001;
    p = (e - 1) % 20;
    if ((p % 5) == 4) return 4'hF;
    return ~(one << (p / 5));
  endfunction

  function automatic logic [7:0] exp_seg(input int e);
    int p;
    p = (e - 1) % 20;
    if ((p % 5) == 4) return 8'hFF;
    return ~exp_dig[p / 5];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vals[0] = 8'h06; vals[1] = 8'h5B; vals[2] = 8'h4F; vals[3] = 8'h66;
    for (int i = 0; i < 4; i++) exp_dig[i] = 8'h00;

    // Reset held 3 cycles with a competing store to DIG0
    rst = 1'b1; we = 1'b1; addr = 8'hFC; wdata = 8'h3F; pb_in = 3'b000;
    repeat (3) tick();
    $display("[TB] reset held 3 cycles with store to 0xFC");
    check("rst_dig0",   rdata,         8'h00);
    check("rst_seg_n",  seg_n,         8'hFF);
    check("rst_an_n",   8'(an_n),      8'h0F);
    check("rst_io_sel", 8'(io_sel),    8'h01);

    rst = 1'b0; we = 1'b0;
    tick();
    $display("[TB] first edge after reset release");
    check("post_rst_an_n",  8'(an_n), 8'h0E);
    check("post_rst_seg_n", seg_n,    8'hFF);

    // Register map: store each digit, read it back the next cycle
    for (k = 0; k < 4; k++) begin
      addr = 8'hFC + 8'(k); wdata = vals[k]; we = 1'b1;
      tick();
      we = 1'b0;
      #1;
      exp_dig[k] = vals[k];
      $display("[TB] write DIG%0d = %02h, read back %02h", k, vals[k], rdata);
      check("raw_dig", rdata, vals[k]);
    end

    addr = 8'hFB; wdata = 8'hAA; we = 1'b1;
    tick();
    we = 1'b0;
    #1;
    $display("[TB] write 0xAA to PB_STATE, read %02h", rdata);
    check("pb_ro", rdata, 8'h00);

    addr = 8'h10; wdata = 8'hFF; we = 1'b1;
    tick();
    we = 1'b0;
    #1;
    $display("[TB] access to 0x10: rdata %02h io_sel %0b", rdata, io_sel);
    check("ram_rdata",  rdata,      8'h00);
    check("ram_io_sel", 8'(io_sel), 8'h00);
    for (k = 0; k < 4; k++) begin
      addr = 8'hFC + 8'(k);
      #1;
      check("dig_kept", rdata, exp_dig[k]);
    end

    // Scan sequence over more than one full period
    for (int i = 0; i < 24; i++) begin
      tick();
      $display("[TB] scan edge %0d: an_n %1h seg_n %02h", n, an_n, seg_n);
      check("scan_an_n",  8'(an_n), 8'(exp_an(n)));
      check("scan_seg_n", seg_n,    exp_seg(n));
    end

    // Collision: store to the digit about to be shown on the BLANK->SHOW edge
    g = 0;
    while ((n % 5) != 4 && g < 10) begin
      tick();
      g = g + 1;
    end
    check("align_coll", 8'((n % 5) == 4), 8'h01);
    k = ((n / 5) + 1) % 4;
    addr = 8'hFC + 8'(k); wdata = 8'h7F; we = 1'b1;
    tick();
    we = 1'b0;
    exp_dig[k] = 8'h7F;
    check("coll_blank_an_n", 8'(an_n), 8'h0F);
    tick();
    $display("[TB] collision on DIG%0d: an_n %1h seg_n %02h", k, an_n, seg_n);
    check("coll_an_n",  8'(an_n), 8'(exp_an(n)));
    check("coll_seg_n", seg_n,    8'h80);

    // Debounce: clean press of left button appears exactly 10 edges later
    addr = 8'hFB;
    pb_in = 3'b010;
    repeat (9) tick();
    check("deb_left_early", rdata, 8'h00);
    tick();
    $display("[TB] left press after 10 edges: PB_STATE %02h", rdata);
    check("deb_left", rdata, 8'h02);

    // 7-cycle glitch on the right button must never be accepted
    pb_in = 3'b110;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("glitch_hold", rdata, 8'h02);
    end
    pb_in = 3'b010;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("glitch_after", rdata, 8'h02);
    end
    $display("[TB] 7-cycle glitch on bit2: PB_STATE %02h", rdata);

    // Center press while left is held
    pb_in = 3'b011;
    repeat (9) tick();
    check("deb_center_early", rdata, 8'h02);
    tick();
    $display("[TB] center press after 10 edges: PB_STATE %02h", rdata);
    check("deb_center", rdata, 8'h03);

    // Mid-operation reset: digit 2 lit, release half debounced
    g = 0;
    while (((n - 1) % 20) != 5 && g < 40) begin
      tick();
      g = g + 1;
    end
    check("align_mid", 8'(((n - 1) % 20) == 5), 8'h01);
    pb_in = 3'b000;
    repeat (6) tick();
    check("mid_an_n",    8'(an_n), 8'h0B);
    check("mid_pending", rdata,    8'h03);
    rst = 1'b1;
    tick();
    $display("[TB] reset mid-scan: an_n %1h seg_n %02h PB_STATE %02h", an_n, seg_n, rdata);
    check("mid_rst_seg_n", seg_n,    8'hFF);
    check("mid_rst_an_n",  8'(an_n), 8'h0F);
    check("mid_rst_pb",    rdata,    8'h00);
    addr = 8'hFE;
    #1;
    check("mid_rst_dig2", rdata, 8'h00);
    rst = 1'b0;
    tick();
    $display("[TB] after mid reset release: an_n %1h seg_n %02h", an_n, seg_n);
    check("mid_restart_an_n",  8'(an_n), 8'h0E);
    check("mid_restart_seg_n", seg_n,    8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
